fll_loop_ctrl: RTL and testbench

FLL_LOOP_CTRL -- requirements
Module: fll_loop_ctrl

---
 rtl/fll_pkg.sv | 23 ++
 rtl/fll_loop_ctrl_if.sv | 34 +++
 rtl/fll_lock_det.sv | 54 +++++
 rtl/fll_loop_ctrl.sv | 114 +++++++++++
 tb/tb_fll_loop_ctrl.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/fll_pkg.sv
// fll_pkg: shared FSM state type, default parameters and mid-scale code helper
// Purpose: common definitions imported by every FLL loop-control file.
// Ports:   none (package).
package fll_pkg;

    typedef enum logic [1:0] {IDLE, SETTLE, TRACK, LOCKED} fll_state_e;

    localparam int FLL_CNT_W      = 16;
    localparam int FLL_CODE_W     = 10;
    localparam int FLL_RANGE_W    = 4;
    localparam int FLL_TOL        = 2;
    localparam int FLL_UNLOCK_TOL = 8;
    localparam int FLL_LOCK_CNT   = 8;
    localparam int FLL_SETTLE_WIN = 2;
    localparam int FLL_GAIN_SHIFT = 2;

    function automatic int mid_code(input int w);
        return 1 << (w - 1);
    endfunction

    localparam int FLL_MID_CODE = mid_code(FLL_CODE_W);

endpackage

// File: rtl/fll_loop_ctrl_if.sv
// fll_loop_ctrl_if: control/measurement/DCO bundle of the FLL loop controller
// Purpose: groups config, count-strobe and DCO outputs into one port.
// Ports:   master drives config/count and observes DCO outputs; slave is the controller.
interface fll_loop_ctrl_if
    import fll_pkg::*;
#(
    parameter int CNT_W   = FLL_CNT_W,
    parameter int CODE_W  = FLL_CODE_W,
    parameter int RANGE_W = FLL_RANGE_W
) ();
    logic               fll_bypass;
    logic               fll_opmode;
    logic               fll_cfgreq;
    logic [RANGE_W-1:0] fll_range;
    logic [CNT_W-1:0]   fll_mult;
    logic [CODE_W-1:0]  fll_open_code;
    logic [CNT_W-1:0]   fll_cnt;
    logic               fll_cnt_vld;
    logic [CODE_W-1:0]  fll_dco_code;
    logic [RANGE_W-1:0] fll_dco_range;
    logic               fll_lock;
    logic               fll_cfgack;
    logic               fll_sat;

    modport master (
        output fll_bypass, fll_opmode, fll_cfgreq, fll_range, fll_mult, fll_open_code, fll_cnt, fll_cnt_vld,
        input  fll_dco_code, fll_dco_range, fll_lock, fll_cfgack, fll_sat
    );

    modport slave (
        input  fll_bypass, fll_opmode, fll_cfgreq, fll_range, fll_mult, fll_open_code, fll_cnt, fll_cnt_vld,
        output fll_dco_code, fll_dco_range, fll_lock, fll_cfgack, fll_sat
    );
endinterface

// File: rtl/fll_lock_det.sv
// fll_lock_det: in-tolerance counter and lock/unlock decision
// Purpose: counts consecutive in-tolerance measurements and holds the lock flag.
// Ports:   clk_i/rst_i clock and async reset; clr_i restarts detection;
//          vld_i qualifies abs_err_i; in_tol_o |err|<=TOL; lock_nxt_o next lock; lock_o lock flag.
module fll_lock_det
    import fll_pkg::*;
#(
    parameter int CNT_W      = FLL_CNT_W,
    parameter int TOL        = FLL_TOL,
    parameter int UNLOCK_TOL = FLL_UNLOCK_TOL,
    parameter int LOCK_CNT   = FLL_LOCK_CNT
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           clr_i,
    input  logic           vld_i,
    input  logic [CNT_W:0] abs_err_i,
    output logic           in_tol_o,
    output logic           lock_nxt_o,
    output logic           lock_o
);
    localparam int CW = $clog2(LOCK_CNT + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          lock_q, lock_d, keep;

    assign in_tol_o   = abs_err_i <= (CNT_W+1)'(TOL);
    assign keep       = abs_err_i <= (CNT_W+1)'(UNLOCK_TOL);
    assign lock_nxt_o = lock_d;
    assign lock_o     = lock_q;

    // Once locked, only a large error drops lock; the counter still restarts on any out-of-tolerance sample.
    always_comb begin
        cnt_d  = cnt_q;
        lock_d = lock_q;
        if (clr_i) begin
            cnt_d  = '0;
            lock_d = 1'b0;
        end else if (vld_i) begin
            cnt_d  = !in_tol_o ? '0 : (cnt_q == CW'(LOCK_CNT) ? cnt_q : cnt_q + CW'(1));
            lock_d = lock_q ? keep : cnt_d == CW'(LOCK_CNT);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            lock_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            lock_q <= lock_d;
        end
    end
endmodule

// File: rtl/fll_loop_ctrl.sv
// fll_loop_ctrl: digital FLL loop controller steering a DCO code from cycle counts
// Purpose: closed/open-loop/bypass control of DCO code and range with lock detection.
// Ports:   fll_ref_clk sole clock; fll_rst async active-high reset;
//          bus (slave) config, count strobe and DCO code/range/lock/ack/sat outputs.
module fll_loop_ctrl
    import fll_pkg::*;
#(
    parameter int CNT_W      = FLL_CNT_W,
    parameter int CODE_W     = FLL_CODE_W,
    parameter int RANGE_W    = FLL_RANGE_W,
    parameter int TOL        = FLL_TOL,
    parameter int UNLOCK_TOL = FLL_UNLOCK_TOL,
    parameter int LOCK_CNT   = FLL_LOCK_CNT,
    parameter int SETTLE_WIN = FLL_SETTLE_WIN,
    parameter int GAIN_SHIFT = FLL_GAIN_SHIFT
) (
    input logic            fll_ref_clk,
    input logic            fll_rst,
    fll_loop_ctrl_if.slave bus
);
    localparam int SW  = (CNT_W > CODE_W ? CNT_W : CODE_W) + 2;
    localparam int STW = $clog2(SETTLE_WIN + 1) + 1;
    localparam logic [CODE_W-1:0]    MID      = CODE_W'(mid_code(CODE_W));
    localparam logic signed [SW-1:0] CODE_MAX = SW'({CODE_W{1'b1}});

    fll_state_e            state_q, state_d;
    logic [CODE_W-1:0]     code_q, code_d;
    logic [RANGE_W-1:0]    range_q, range_d;
    logic [CNT_W-1:0]      mult_q, mult_d;
    logic [STW-1:0]        settle_q, settle_d;
    logic                  sat_q, sat_d, ack_q;
    logic signed [CNT_W:0] err, sh, step;
    logic [CNT_W:0]        abs_err;
    logic signed [SW-1:0]  sum;
    logic                  loop_on, det_clr, det_vld, in_tol, lock_nxt, lock;

    assign loop_on = !bus.fll_bypass && bus.fll_opmode;
    assign det_clr = bus.fll_cfgreq || !loop_on;
    assign det_vld = bus.fll_cnt_vld && (state_q == TRACK || state_q == LOCKED);
    assign err     = $signed({1'b0, mult_q}) - $signed({1'b0, bus.fll_cnt});
    assign abs_err = err[CNT_W] ? $unsigned(-err) : $unsigned(err);
    // An arithmetic shift never rounds a negative error to zero, so only +1 needs forcing.
    assign sh      = err >>> GAIN_SHIFT;
    assign step    = sh == '0 ? (CNT_W+1)'(1) : sh;
    // Extra headroom bits so both under- and overflow of the code are visible before clamping.
    assign sum     = SW'(step) + $signed(SW'(code_q));

    fll_lock_det #(
        .CNT_W(CNT_W), .TOL(TOL), .UNLOCK_TOL(UNLOCK_TOL), .LOCK_CNT(LOCK_CNT)
    ) u_lock_det (
        .clk_i(fll_ref_clk), .rst_i(fll_rst), .clr_i(det_clr), .vld_i(det_vld),
        .abs_err_i(abs_err), .in_tol_o(in_tol), .lock_nxt_o(lock_nxt), .lock_o(lock)
    );

    // Priority: config request, then bypass/open loop, then measurement strobes.
    always_comb begin
        state_d  = state_q;
        code_d   = code_q;
        range_d  = range_q;
        mult_d   = mult_q;
        settle_d = settle_q;
        sat_d    = sat_q;
        if (bus.fll_cfgreq) begin
            range_d = bus.fll_bypass ? range_q : bus.fll_range;
            state_d = loop_on ? SETTLE : IDLE;
            if (loop_on) begin
                code_d   = MID;
                mult_d   = bus.fll_mult;
                sat_d    = 1'b0;
                settle_d = '0;
            end else if (!bus.fll_bypass) begin
                code_d = bus.fll_open_code;
            end
        end else if (!loop_on) begin
            state_d = IDLE;
            code_d  = bus.fll_bypass ? code_q : bus.fll_open_code;
        end else if (bus.fll_cnt_vld && state_q == SETTLE) begin
            settle_d = settle_q + STW'(1);
            state_d  = settle_d >= STW'(SETTLE_WIN) ? TRACK : SETTLE;
        end else if (det_vld) begin
            state_d = lock_nxt ? LOCKED : TRACK;
            if (!in_tol) begin
                code_d = sum[SW-1] ? '0 : (sum > CODE_MAX ? '1 : sum[CODE_W-1:0]);
                sat_d  = sat_q || sum[SW-1] || sum > CODE_MAX;
            end
        end
    end

    always_ff @(posedge fll_ref_clk or posedge fll_rst) begin
        if (fll_rst) begin
            state_q  <= IDLE;
            code_q   <= MID;
            range_q  <= '0;
            mult_q   <= '0;
            settle_q <= '0;
            sat_q    <= 1'b0;
            ack_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            code_q   <= code_d;
            range_q  <= range_d;
            mult_q   <= mult_d;
            settle_q <= settle_d;
            sat_q    <= sat_d;
            ack_q    <= bus.fll_cfgreq;
        end
    end

    assign bus.fll_dco_code  = code_q;
    assign bus.fll_dco_range = range_q;
    assign bus.fll_lock      = lock;
    assign bus.fll_cfgack    = ack_q;
    assign bus.fll_sat       = sat_q;
endmodule

// File: tb/tb_fll_loop_ctrl.sv
// tb_fll_loop_ctrl: self-checking bench for fll_loop_ctrl with a behavioural model
// Purpose: directed stimulus, per-cycle model comparison and literal spot checks.
// Ports:   none (top-level bench).
module tb_fll_loop_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;

    fll_loop_ctrl_if bus ();
    fll_loop_ctrl dut (.fll_ref_clk(clk), .fll_rst(rst), .bus(bus));

    always #5 clk = ~clk;

    // Model state: phase 0 idle, 1 settling, 2 tracking, 3 locked.
    int m_code = 512, m_range = 0, m_mult = 0, m_intol = 0, m_seen = 0, m_phase = 0;
    bit m_lock = 0, m_ack = 0, m_sat = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk or posedge rst) begin : mdl
        int e, mag, st, nc, n_code, n_intol, n_seen, n_phase;
        bit n_lock, n_sat;
        if (rst) begin
            m_code <= 512; m_range <= 0; m_mult <= 0; m_intol <= 0; m_seen <= 0;
            m_phase <= 0; m_lock <= 0; m_ack <= 0; m_sat <= 0;
        end else begin
            n_code = m_code; n_lock = m_lock; n_sat = m_sat;
            n_intol = m_intol; n_seen = m_seen; n_phase = m_phase;
            if (bus.fll_cfgreq) begin
                if (!bus.fll_bypass) m_range <= int'(bus.fll_range);
                if (!bus.fll_bypass && bus.fll_opmode) begin
                    m_mult <= int'(bus.fll_mult);
                    n_code = 512; n_lock = 0; n_sat = 0; n_intol = 0; n_seen = 0; n_phase = 1;
                end else begin
                    n_lock = 0; n_phase = 0;
                    if (!bus.fll_bypass) n_code = int'(bus.fll_open_code);
                end
            end else if (bus.fll_bypass) begin
                n_lock = 0; n_phase = 0;
            end else if (!bus.fll_opmode) begin
                n_lock = 0; n_phase = 0; n_code = int'(bus.fll_open_code);
            end else if (bus.fll_cnt_vld && n_phase == 1) begin
                n_seen++;
                if (n_seen == 2) n_phase = 2;
            end else if (bus.fll_cnt_vld && n_phase >= 2) begin
                e = m_mult - int'(bus.fll_cnt);
                mag = e < 0 ? -e : e;
                if (mag > 2) begin
                    st = e >= 0 ? e / 4 : -((3 - e) / 4);
                    if (st == 0) st = 1;
                    nc = n_code + st;
                    if (nc < 0 || nc > 1023) n_sat = 1;
                    n_code = nc < 0 ? 0 : (nc > 1023 ? 1023 : nc);
                end
                if (n_phase == 3 && mag > 8) begin
                    n_lock = 0; n_phase = 2; n_intol = 0;
                end else if (mag <= 2) begin
                    if (n_intol < 8) n_intol++;
                end else begin
                    n_intol = 0;
                end
                if (n_phase == 2 && n_intol == 8) begin
                    n_lock = 1; n_phase = 3;
                end
            end
            m_ack <= bus.fll_cfgreq;
            m_code <= n_code; m_lock <= n_lock; m_sat <= n_sat;
            m_intol <= n_intol; m_seen <= n_seen; m_phase <= n_phase;
        end
    end

    always @(negedge clk) begin
        chk("code", int'(bus.fll_dco_code), m_code);
        chk("range", int'(bus.fll_dco_range), m_range);
        chk("lock", int'(bus.fll_lock), int'(m_lock));
        chk("cfgack", int'(bus.fll_cfgack), int'(m_ack));
        chk("sat", int'(bus.fll_sat), int'(m_sat));
    end

    task automatic strobe(input logic [15:0] c);
        bus.fll_cnt = c;
        bus.fll_cnt_vld = 1'b1;
        @(negedge clk);
        bus.fll_cnt_vld = 1'b0;
    endtask

    task automatic cfg(input logic [3:0] r, input logic [15:0] m);
        bus.fll_cfgreq = 1'b1;
        bus.fll_range = r;
        bus.fll_mult = m;
        @(negedge clk);
        bus.fll_cfgreq = 1'b0;
    endtask

    task automatic lock_up(input logic [3:0] r);
        cfg(r, 16'd100);
        repeat (2) strobe(16'd100);
        repeat (8) strobe(16'd100);
    endtask

    initial begin
        bus.fll_bypass = 1'b0; bus.fll_opmode = 1'b1; bus.fll_cfgreq = 1'b0;
        bus.fll_range = '0; bus.fll_mult = '0; bus.fll_open_code = '0;
        bus.fll_cnt = '0; bus.fll_cnt_vld = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_code", int'(bus.fll_dco_code), 512);
        chk("rst_range", int'(bus.fll_dco_range), 0);
        chk("rst_lock", int'(bus.fll_lock), 0);
        chk("rst_ack", int'(bus.fll_cfgack), 0);
        chk("rst_sat", int'(bus.fll_sat), 0);
        rst = 1'b0;
        strobe(16'd0);
        chk("idle_ignores_cnt", int'(bus.fll_dco_code), 512);

        cfg(4'd5, 16'd100);
        chk("ack_pulse", int'(bus.fll_cfgack), 1);
        chk("cfg_range", int'(bus.fll_dco_range), 5);
        @(negedge clk);
        chk("ack_single", int'(bus.fll_cfgack), 0);
        repeat (2) strobe(16'd100);
        repeat (7) strobe(16'd100);
        chk("lock_before_8th", int'(bus.fll_lock), 0);
        strobe(16'd100);
        chk("lock_after_8th", int'(bus.fll_lock), 1);
        chk("code_held_512", int'(bus.fll_dco_code), 512);
        strobe(16'd105);
        chk("locked_105_lock", int'(bus.fll_lock), 1);
        chk("locked_105_code", int'(bus.fll_dco_code), 510);
        strobe(16'd109);
        chk("unlock_109_lock", int'(bus.fll_lock), 0);
        chk("unlock_109_code", int'(bus.fll_dco_code), 507);
        repeat (7) strobe(16'd100);
        chk("relock_cnt_restart", int'(bus.fll_lock), 0);
        strobe(16'd100);
        chk("relock", int'(bus.fll_lock), 1);

        cfg(4'd5, 16'd100);
        repeat (2) strobe(16'd100);
        strobe(16'd80);
        chk("step_plus5", int'(bus.fll_dco_code), 517);
        strobe(16'd97);
        chk("min_step", int'(bus.fll_dco_code), 518);
        strobe(16'd99);
        chk("in_tol_99", int'(bus.fll_dco_code), 518);
        strobe(16'd101);
        chk("in_tol_101", int'(bus.fll_dco_code), 518);
        strobe(16'd103);
        chk("step_minus1", int'(bus.fll_dco_code), 517);

        cfg(4'd3, 16'd1000);
        repeat (2) strobe(16'd0);
        strobe(16'd0);
        chk("big_step_1", int'(bus.fll_dco_code), 762);
        strobe(16'd0);
        chk("big_step_2", int'(bus.fll_dco_code), 1012);
        chk("no_sat_yet", int'(bus.fll_sat), 0);
        strobe(16'd0);
        chk("clamp_code", int'(bus.fll_dco_code), 1023);
        chk("clamp_sat", int'(bus.fll_sat), 1);
        strobe(16'd0);
        chk("sat_sticky", int'(bus.fll_sat), 1);
        cfg(4'd3, 16'd100);
        chk("cfg_clears_sat", int'(bus.fll_sat), 0);
        chk("cfg_mid_code", int'(bus.fll_dco_code), 512);

        repeat (2) strobe(16'd100);
        bus.fll_cfgreq = 1'b1; bus.fll_range = 4'd2; bus.fll_mult = 16'd100;
        bus.fll_cnt = 16'd0; bus.fll_cnt_vld = 1'b1;
        @(negedge clk);
        bus.fll_cfgreq = 1'b0; bus.fll_cnt_vld = 1'b0;
        chk("coinc_discard", int'(bus.fll_dco_code), 512);
        chk("coinc_ack", int'(bus.fll_cfgack), 1);
        repeat (2) strobe(16'd0);
        chk("coinc_settle", int'(bus.fll_dco_code), 512);
        strobe(16'd0);
        chk("coinc_track", int'(bus.fll_dco_code), 537);

        lock_up(4'd6);
        chk("byp_prelock", int'(bus.fll_lock), 1);
        bus.fll_bypass = 1'b1;
        @(negedge clk);
        chk("byp_lock", int'(bus.fll_lock), 0);
        chk("byp_code", int'(bus.fll_dco_code), 512);
        strobe(16'd0);
        chk("byp_ignores_cnt", int'(bus.fll_dco_code), 512);
        cfg(4'd9, 16'd100);
        chk("byp_ack", int'(bus.fll_cfgack), 1);
        chk("byp_range_held", int'(bus.fll_dco_range), 6);
        bus.fll_bypass = 1'b0;
        strobe(16'd0);
        chk("byp_no_loop", int'(bus.fll_dco_code), 512);

        bus.fll_opmode = 1'b0;
        bus.fll_open_code = 10'd300;
        @(negedge clk);
        chk("open_code", int'(bus.fll_dco_code), 300);
        chk("open_lock", int'(bus.fll_lock), 0);
        cfg(4'd7, 16'd100);
        chk("open_ack", int'(bus.fll_cfgack), 1);
        chk("open_range", int'(bus.fll_dco_range), 7);
        bus.fll_opmode = 1'b1;
        strobe(16'd0);
        chk("open_to_idle", int'(bus.fll_dco_code), 300);

        lock_up(4'd4);
        strobe(16'd105);
        chk("pre_rst_code", int'(bus.fll_dco_code), 510);
        chk("pre_rst_lock", int'(bus.fll_lock), 1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_code", int'(bus.fll_dco_code), 512);
        chk("async_lock", int'(bus.fll_lock), 0);
        chk("async_range", int'(bus.fll_dco_range), 0);
        chk("async_ack", int'(bus.fll_cfgack), 0);
        chk("async_sat", int'(bus.fll_sat), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        strobe(16'd0);
        chk("no_resume_code", int'(bus.fll_dco_code), 512);
        chk("no_resume_lock", int'(bus.fll_lock), 0);
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
